// File: rtl/hls_kernel_pkg.sv
// Shared definitions for generated top-level kernels: state encoding and width.
package hls_kernel_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/hls_operand_ram.sv
// Operand storage: one synchronous write port, one asynchronous read port.
module hls_operand_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; addresses beyond the array are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/hls_dot_product.sv
// Dot-product kernel over two preloaded operand arrays with start/finished handshake.
// Optional macro HLS_DOT_SAT_EN selects a saturating accumulator instead of wrap-around.
module hls_dot_product
  import hls_kernel_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              finished,
  output logic [WIDTH-1:0]  return_val
);

`ifdef HLS_DOT_SAT_EN
  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = 2 * WIDTH + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};
`else
  // Wrap mode only ever consumes the low half of the product.
  localparam int PROD_W = WIDTH;
`endif
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  state_e                    state_r;
  state_e                    state_s;
  logic [ADDR_W-1:0]         idx_r;
  logic [WIDTH-1:0]          acc_r;
  logic signed [PROD_W-1:0]  prod_r;
  logic                      finished_r;
  logic [WIDTH-1:0]          return_val_r;
  logic [WIDTH-1:0]          sum_s;
  logic [WIDTH-1:0]          a_rd_s;
  logic [WIDTH-1:0]          b_rd_s;
  logic                      wr_ok_s;
`ifdef HLS_DOT_SAT_EN
  logic                      sat_r;
  logic                      hit_s;
  logic signed [SUM_W-1:0]   wide_s;
`endif

  assign wr_ok_s = wr_en && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  hls_operand_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_a (
    .clk     (clk),
    .wr_en   (wr_ok_s && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_r),
    .rd_data (a_rd_s)
  );

  hls_operand_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_b (
    .clk     (clk),
    .wr_en   (wr_ok_s && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_r),
    .rd_data (b_rd_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_INIT;
        else       state_s = ST_IDLE;
      end
      ST_INIT: state_s = ST_MUL;
      ST_MUL:  state_s = ST_ACC;
      ST_ACC: begin
        if (idx_r == IDX_LAST) state_s = ST_DONE;
        else                   state_s = ST_MUL;
      end
      ST_DONE: begin
        if (start) state_s = ST_INIT;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

`ifdef HLS_DOT_SAT_EN
  // Saturating add on the full product; a clamped accumulator stays pinned until INIT.
  always_comb begin
    wide_s = {{(WIDTH+2){acc_r[WIDTH-1]}}, acc_r} + {{2{prod_r[PROD_W-1]}}, prod_r};
    sum_s  = wide_s[WIDTH-1:0];
    hit_s  = 1'b0;
    if (sat_r) begin
      sum_s = acc_r;
      hit_s = 1'b1;
    end else if (wide_s > SAT_MAX) begin
      sum_s = SAT_MAX[WIDTH-1:0];
      hit_s = 1'b1;
    end else if (wide_s < SAT_MIN) begin
      sum_s = SAT_MIN[WIDTH-1:0];
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end
`else
  // Truncating modulo-2^WIDTH add.
  always_comb begin
    sum_s = acc_r + prod_r;
  end
`endif

  // Datapath and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      acc_r        <= '0;
      prod_r       <= '0;
      finished_r   <= 1'b0;
      return_val_r <= '0;
`ifdef HLS_DOT_SAT_EN
      sat_r        <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      finished_r <= (state_s == ST_DONE);
      case (state_r)
        ST_INIT: begin
          acc_r <= '0;
          idx_r <= '0;
`ifdef HLS_DOT_SAT_EN
          sat_r <= 1'b0;
`endif
        end
        ST_MUL: prod_r <= $signed(a_rd_s) * $signed(b_rd_s);
        ST_ACC: begin
          acc_r <= sum_s;
`ifdef HLS_DOT_SAT_EN
          sat_r <= hit_s;
`endif
          if (idx_r == IDX_LAST) return_val_r <= sum_s;
          else                   idx_r        <= idx_r + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign finished   = finished_r;
  assign return_val = return_val_r;

endmodule

// File: tb/tb_hls_dot_product.sv
// Self-checking bench: table vectors, random vectors against an arithmetic model, corner sequences.
module tb_hls_dot_product;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  start;
  logic        wr_en;
  logic        wr_sel;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  fin;
  logic [31:0] rv0, rv1, rv2;
  logic [7:0]  rv3;

  int checks = 0;
  int fails  = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];

  typedef struct {
    string            name;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [31:0]      exp;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  hls_dot_product #(.WIDTH(32), .DEPTH(8)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .finished(fin[0]), .return_val(rv0));
  hls_dot_product #(.WIDTH(32), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr[1:0]), .wr_data(wr_data), .finished(fin[1]), .return_val(rv1));
  hls_dot_product #(.WIDTH(32), .DEPTH(1)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr[0:0]), .wr_data(wr_data), .finished(fin[2]), .return_val(rv2));
  hls_dot_product #(.WIDTH(8), .DEPTH(2)) dut3 (
    .clk(clk), .reset(reset), .start(start[3]), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr[0:0]), .wr_data(wr_data[7:0]), .finished(fin[3]), .return_val(rv3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_main();
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, va[i]);
      wr(1'b1, i, vb[i]);
    end
  endtask

  // Start already sampled on edge number 'edges'; wait (bounded) for finished.
  task automatic wait_fin(input int k, inout int edges);
    while (!fin[k] && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic kick(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  function automatic logic [31:0] model_dot();
    longint acc;
    longint p;
    bit     stuck;
    acc = 0;
    stuck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = longint'($signed(va[i])) * longint'($signed(vb[i]));
`ifdef HLS_DOT_SAT_EN
      if (!stuck) begin
        acc = acc + p;
        if (acc > 64'sd2147483647) begin
          acc = 64'sd2147483647; stuck = 1'b1;
        end else if (acc < -64'sd2147483648) begin
          acc = -64'sd2147483648; stuck = 1'b1;
        end
      end
`else
      acc = acc + p;
`endif
    end
    return acc[31:0];
  endfunction

  initial begin
    int edges;
    logic [31:0] exp4;

    reset = 1'b1; start = 4'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;

    for (int t = 0; t < 5; t++) begin
      tbl[t].a = '0;
      tbl[t].b = '0;
    end
    tbl[0].name = "mixed_sign";
    tbl[0].a[0] = -32'sd3; tbl[0].a[1] = 32'd4; tbl[0].b[0] = 32'd7; tbl[0].b[1] = -32'sd2;
    tbl[0].exp  = 32'hFFFF_FFE3;
    tbl[1].name = "ramp";
    for (int i = 0; i < 8; i++) begin
      tbl[1].a[i] = 32'(i + 1);
      tbl[1].b[i] = 32'(i + 1);
    end
    tbl[1].exp  = 32'd204;
    tbl[2].name = "zeros";
    tbl[2].exp  = 32'd0;
    tbl[3].name = "last_only";
    tbl[3].a[7] = 32'hFFFF_FFFF; tbl[3].b[7] = 32'hFFFF_FFFF;
    tbl[3].exp  = 32'd1;
    tbl[4].name = "alternating";
    for (int i = 0; i < 8; i++) begin
      tbl[4].a[i] = 32'(1000 + i);
      tbl[4].b[i] = (i % 2 == 0) ? 32'd1 : 32'hFFFF_FFFF;
    end
    tbl[4].exp  = 32'hFFFF_FFFC;

    tick(); tick();
    reset = 1'b0;
    chk("reset_finished", {28'd0, fin}, 32'd0);
    chk("reset_rv0", rv0, 32'd0);
    chk("reset_rv3", {24'd0, rv3}, 32'd0);

    // Table vectors on the DEPTH=8 instance.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) begin
        va[i] = tbl[t].a[i];
        vb[i] = tbl[t].b[i];
      end
      load_main();
      kick(0);
      edges = 1;
      wait_fin(0, edges);
      chk({tbl[t].name, "_latency"}, 32'(edges), 32'd18);
      chk(tbl[t].name, rv0, tbl[t].exp);
    end

    // Random vectors: half small-range, half full-range.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        if (r < 4) begin
          va[i] = 32'($urandom_range(0, 400)) - 32'd200;
          vb[i] = 32'($urandom_range(0, 400)) - 32'd200;
        end else begin
          va[i] = $urandom;
          vb[i] = $urandom;
        end
      end
      load_main();
      kick(0);
      edges = 1;
      wait_fin(0, edges);
      chk("rand_latency", 32'(edges), 32'd18);
      chk("rand_result", rv0, model_dot());
    end

    // DEPTH=4: last write coincides with start and must be used.
    wr(1'b0, 0, 32'd1); wr(1'b0, 1, 32'd2); wr(1'b0, 2, 32'd3); wr(1'b0, 3, 32'd4);
    wr(1'b1, 0, 32'd5); wr(1'b1, 1, 32'd6); wr(1'b1, 2, 32'd7);
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd3; wr_data = 32'd8; start[1] = 1'b1;
    tick();
    wr_en = 1'b0; start[1] = 1'b0;
    edges = 1;
    wait_fin(1, edges);
    chk("d4_latency", 32'(edges), 32'd10);
    chk("d4_result", rv1, 32'd70);

    // DEPTH=1: out-of-range address write is ignored.
    wr(1'b0, 0, 32'd2); wr(1'b1, 0, 32'd3);
    wr(1'b0, 1, 32'd100); wr(1'b1, 1, 32'd100);
    kick(2);
    edges = 1;
    wait_fin(2, edges);
    chk("d1_latency", 32'(edges), 32'd4);
    chk("d1_result", rv2, 32'd6);

    // WIDTH=8 DEPTH=2 overflow.
`ifdef HLS_DOT_SAT_EN
    exp4 = 32'd127;
`else
    exp4 = 32'd44;
`endif
    wr(1'b0, 0, 32'd100); wr(1'b0, 1, 32'd100); wr(1'b1, 0, 32'd2); wr(1'b1, 1, 32'd1);
    kick(3);
    edges = 1;
    wait_fin(3, edges);
    chk("w8_latency", 32'(edges), 32'd6);
    chk("w8_overflow", {24'd0, rv3}, exp4);

    // Reset on the third edge of a run aborts it.
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'(i + 1);
      vb[i] = 32'(i + 1);
    end
    load_main();
    kick(0);
    edges = 1;
    wait_fin(0, edges);
    chk("pre_reset_result", rv0, 32'd204);
    kick(0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_finished", {31'd0, fin[0]}, 32'd0);
    chk("abort_rv", rv0, 32'd0);
    for (int i = 0; i < 25; i++) tick();
    chk("abort_stays_idle", {31'd0, fin[0]}, 32'd0);
    kick(0);
    edges = 1;
    wait_fin(0, edges);
    chk("rerun_latency", 32'(edges), 32'd18);
    chk("rerun_result", rv0, 32'd204);

    // Writes and start during a run are ignored.
    kick(0);
    edges = 1;
    tick(); tick();
    edges = 3;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 32'd999; start[0] = 1'b1;
    tick();
    edges = 4;
    wr_en = 1'b0; start[0] = 1'b0;
    wait_fin(0, edges);
    chk("midrun_latency", 32'(edges), 32'd18);
    chk("midrun_result", rv0, 32'd204);
    tick(); tick(); tick();
    chk("done_holds_fin", {31'd0, fin[0]}, 32'd1);
    chk("done_holds_rv", rv0, 32'd204);
    kick(0);
    chk("start_in_done_drops_fin", {31'd0, fin[0]}, 32'd0);
    edges = 1;
    wait_fin(0, edges);
    chk("repeat_result", rv0, 32'd204);

    // Writes in DONE are honoured.
    wr(1'b0, 0, 32'd10);
    kick(0);
    edges = 1;
    wait_fin(0, edges);
    chk("write_in_done", rv0, 32'd213);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
